// File: rtl/wb_pkg.sv
// Shared constants and types for the Minisys-1A registered write-back stage.
package wb_pkg;

  localparam logic [2:0] LT_LB  = 3'd0;
  localparam logic [2:0] LT_LBU = 3'd1;
  localparam logic [2:0] LT_LH  = 3'd2;
  localparam logic [2:0] LT_LHU = 3'd3;
  localparam logic [2:0] LT_LW  = 3'd4;

  localparam int WAIT_MAX_DEFAULT = 15;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  // Width of a counter that must be able to hold max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian load alignment: picks the addressed lane of the read word and extends it.
// Sub-word loads (LB/LBU/LH/LHU) and misalign detection exist only when LOAD_SUBWORD_EN is defined.
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] read_data,
  input  logic [2:0]        load_type,
  input  logic [AW-1:0]     addr_lo,
  output logic [DATA_W-1:0] aligned,
  output logic              misalign
);

  logic [AW-1:0] word_off;
  logic [31:0]   word_v;

`ifdef LOAD_SUBWORD_EN
  logic [AW-1:0] half_off;
  logic [15:0]   half_v;
  logic [7:0]    byte_v;

  always_comb begin
    word_off = addr_lo & ~AW'(3);
    half_off = addr_lo & ~AW'(1);
    word_v   = 32'(read_data >> {word_off, 3'b000});
    half_v   = 16'(read_data >> {half_off, 3'b000});
    byte_v   = 8'(read_data >> {addr_lo, 3'b000});
    aligned  = DATA_W'($signed(word_v));
    misalign = 1'b0;
    case (load_type)
      LT_LB:  aligned = DATA_W'($signed(byte_v));
      LT_LBU: aligned = DATA_W'(byte_v);
      LT_LH: begin
        aligned  = DATA_W'($signed(half_v));
        misalign = addr_lo[0];
      end
      LT_LHU: begin
        aligned  = DATA_W'(half_v);
        misalign = addr_lo[0];
      end
      // LW and the unused encodings behave as a word load
      default: misalign = |addr_lo[1:0];
    endcase
  end
`else
  logic unused_load_type;

  assign unused_load_type = ^load_type;

  always_comb begin
    word_off = addr_lo & ~AW'(3);
    word_v   = 32'(read_data >> {word_off, 3'b000});
    aligned  = DATA_W'($signed(word_v));
    misalign = 1'b0;
  end
`endif

endmodule

// File: rtl/wb_stage.sv
// Registered MEM/WB write-back stage with load alignment, link select and a timed I/O wait state.
// Define LOAD_SUBWORD_EN to enable byte/halfword loads and misalign detection.
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic                         flush,
  input  logic [DATA_W-1:0]            ALU_result,
  input  logic [DATA_W-1:0]            read_data,
  input  logic                         rdata_valid,
  input  logic                         MemIOtoReg,
  input  logic [2:0]                   load_type,
  input  logic [$clog2(DATA_W/8)-1:0]  addr_lo,
  input  logic                         link,
  input  logic [DATA_W-1:0]            link_addr,
  input  logic                         RegWrite,
  input  logic [REG_AW-1:0]            wreg,
  output logic                         wb_we,
  output logic [REG_AW-1:0]            wb_addr,
  output logic [DATA_W-1:0]            wb_data,
  output logic                         misalign,
  output logic                         bus_err
);

  localparam int AW    = $clog2(DATA_W / 8);
  localparam int CNT_W = cnt_width(WAIT_MAX);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          lt_q, lt_d;
  logic [AW-1:0]       alo_q, alo_d;
  logic                rw_q, rw_d;
  logic [REG_AW-1:0]   wreg_q, wreg_d;
  logic                wb_we_q, wb_we_d;
  logic [REG_AW-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                misalign_q, misalign_d;
  logic                bus_err_q, bus_err_d;

  logic [2:0]          sel_lt;
  logic [AW-1:0]       sel_alo;
  logic [DATA_W-1:0]   al_data;
  logic                al_misalign;

  logic                commit;
  logic                commit_rw;
  logic [REG_AW-1:0]   commit_wreg;
  logic [DATA_W-1:0]   commit_data;

  // While waiting, alignment uses the fields captured at accept, not the live MEM inputs.
  assign sel_lt  = (state_q == S_WAIT) ? lt_q  : load_type;
  assign sel_alo = (state_q == S_WAIT) ? alo_q : addr_lo;

  load_align #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_align (
    .read_data (read_data),
    .load_type (sel_lt),
    .addr_lo   (sel_alo),
    .aligned   (al_data),
    .misalign  (al_misalign)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lt_d        = lt_q;
    alo_d       = alo_q;
    rw_d        = rw_q;
    wreg_d      = wreg_q;
    wb_we_d     = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    commit      = 1'b0;
    commit_rw   = RegWrite;
    commit_wreg = wreg;
    commit_data = ALU_result;

    case (state_q)
      S_IDLE: begin
        if (mem_valid && !flush) begin
          if (link) begin
            commit      = 1'b1;
            commit_data = link_addr;
          end else if (MemIOtoReg) begin
            if (!rdata_valid) begin
              state_d = S_WAIT;
              cnt_d   = '0;
              lt_d    = load_type;
              alo_d   = addr_lo;
              rw_d    = RegWrite;
              wreg_d  = wreg;
            end else if (al_misalign) begin
              misalign_d = 1'b1;
            end else begin
              commit      = 1'b1;
              commit_data = al_data;
            end
          end else begin
            commit = 1'b1;
          end
        end
      end

      // flush outranks arriving data, which outranks the timeout
      S_WAIT: begin
        commit_rw   = rw_q;
        commit_wreg = wreg_q;
        commit_data = al_data;
        if (flush) begin
          state_d = S_IDLE;
        end else if (rdata_valid) begin
          state_d = S_IDLE;
          if (al_misalign) begin
            misalign_d = 1'b1;
          end else begin
            commit = 1'b1;
          end
        end else if (cnt_q == CNT_W'(WAIT_MAX)) begin
          state_d   = S_IDLE;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      wb_we_d   = commit_rw && (commit_wreg != '0);
      wb_addr_d = commit_wreg;
      wb_data_d = commit_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lt_q       <= '0;
      alo_q      <= '0;
      rw_q       <= 1'b0;
      wreg_q     <= '0;
      wb_we_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lt_q       <= lt_d;
      alo_q      <= alo_d;
      rw_q       <= rw_d;
      wreg_q     <= wreg_d;
      wb_we_q    <= wb_we_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign mem_ready = (state_q != S_WAIT);
  assign wb_we     = wb_we_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign misalign  = misalign_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed vector table, multi-cycle wait/timeout/flush/reset sequences,
// and randomized traffic against a behavioural model. Expectations follow LOAD_SUBWORD_EN.
module tb_wb_stage;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int WAIT_MAX = 15;
`ifdef LOAD_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        mem_valid;
  logic        mem_ready;
  logic        flush;
  logic [31:0] ALU_result;
  logic [31:0] read_data;
  logic        rdata_valid;
  logic        MemIOtoReg;
  logic [2:0]  load_type;
  logic [1:0]  addr_lo;
  logic        link;
  logic [31:0] link_addr;
  logic        RegWrite;
  logic [4:0]  wreg;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        misalign;
  logic        bus_err;

  wb_stage #(
    .DATA_W   (DATA_W),
    .REG_AW   (REG_AW),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .flush       (flush),
    .ALU_result  (ALU_result),
    .read_data   (read_data),
    .rdata_valid (rdata_valid),
    .MemIOtoReg  (MemIOtoReg),
    .load_type   (load_type),
    .addr_lo     (addr_lo),
    .link        (link),
    .link_addr   (link_addr),
    .RegWrite    (RegWrite),
    .wreg        (wreg),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .misalign    (misalign),
    .bus_err     (bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        valid;
    logic        flush;
    logic        rv;
    logic        mio;
    logic        lnk;
    logic        rw;
    logic [2:0]  lt;
    logic [1:0]  alo;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [31:0] la;
    logic [4:0]  wreg;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[12];
  int   checks = 0;
  int   passes = 0;

  // model state
  logic        m_pend;
  int          m_cnt;
  logic [2:0]  m_lt;
  logic [1:0]  m_alo;
  logic        m_rw;
  logic [4:0]  m_wreg;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        e_we;
  logic        e_mis;
  logic        e_berr;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    mem_valid   = 1'b0;
    flush       = 1'b0;
    ALU_result  = 32'h0;
    read_data   = 32'h0;
    rdata_valid = 1'b0;
    MemIOtoReg  = 1'b0;
    load_type   = 3'd4;
    addr_lo     = 2'd0;
    link        = 1'b0;
    link_addr   = 32'h0;
    RegWrite    = 1'b0;
    wreg        = 5'd0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    mem_valid   = v.valid;
    flush       = v.flush;
    rdata_valid = v.rv;
    MemIOtoReg  = v.mio;
    link        = v.lnk;
    RegWrite    = v.rw;
    load_type   = v.lt;
    addr_lo     = v.alo;
    ALU_result  = v.alu;
    read_data   = v.rd;
    link_addr   = v.la;
    wreg        = v.wreg;
  endtask

  function automatic vec_t mk(input logic v, input logic f, input logic rv, input logic mio,
                              input logic lnk, input logic rw, input logic [2:0] lt,
                              input logic [1:0] alo, input logic [31:0] alu, input logic [31:0] rd,
                              input logic [31:0] la, input logic [4:0] wr, input logic we,
                              input logic [4:0] ea, input logic [31:0] ed, input logic em);
    vec_t r;
    r = '{valid: v, flush: f, rv: rv, mio: mio, lnk: lnk, rw: rw, lt: lt, alo: alo, alu: alu,
          rd: rd, la: la, wreg: wr, exp_we: we, exp_addr: ea, exp_data: ed, exp_mis: em};
    return r;
  endfunction

  // Reference load alignment from the little-endian lane rules.
  task automatic model_load(input logic [31:0] rd, input logic [2:0] lt, input logic [1:0] alo,
                            output logic mis, output logic [31:0] val);
    int unsigned b;
    int unsigned h;
    mis = 1'b0;
    val = rd;
    if (SUB) begin
      b = (rd >> (8 * alo)) & 32'hFF;
      h = (rd >> (16 * (alo / 2))) & 32'hFFFF;
      case (lt)
        3'd0: val = (b >= 128) ? (b | 32'hFFFFFF00) : b;
        3'd1: val = b;
        3'd2: begin val = (h >= 32768) ? (h | 32'hFFFF0000) : h; mis = (alo % 2) != 0; end
        3'd3: begin val = h; mis = (alo % 2) != 0; end
        default: mis = (alo != 0);
      endcase
    end
  endtask

  function automatic void model_commit(input logic rw, input logic [4:0] wr, input logic [31:0] v);
    e_we   = rw && (wr != 5'd0);
    m_addr = wr;
    m_data = v;
  endfunction

  task automatic model_step();
    logic        mis;
    logic [31:0] val;
    e_we   = 1'b0;
    e_mis  = 1'b0;
    e_berr = 1'b0;
    if (!m_pend) begin
      if (mem_valid && !flush) begin
        if (link) model_commit(RegWrite, wreg, link_addr);
        else if (MemIOtoReg) begin
          if (rdata_valid) begin
            model_load(read_data, load_type, addr_lo, mis, val);
            if (mis) e_mis = 1'b1;
            else model_commit(RegWrite, wreg, val);
          end else begin
            m_pend = 1'b1;
            m_cnt  = 0;
            m_lt   = load_type;
            m_alo  = addr_lo;
            m_rw   = RegWrite;
            m_wreg = wreg;
          end
        end else model_commit(RegWrite, wreg, ALU_result);
      end
    end else begin
      if (flush) m_pend = 1'b0;
      else if (rdata_valid) begin
        m_pend = 1'b0;
        model_load(read_data, m_lt, m_alo, mis, val);
        if (mis) e_mis = 1'b1;
        else model_commit(m_rw, m_wreg, val);
      end else if (m_cnt == WAIT_MAX) begin
        m_pend = 1'b0;
        e_berr = 1'b1;
      end else m_cnt++;
    end
  endtask

  initial begin
    int low;
    int waits;
    logic seen;
    logic wrote;

    vecs[0]  = mk(1,0,1,0,0,1, 3'd4,2'd0, 32'h12345678, 32'h0, 32'h0, 5'd8,
                  1, 5'd8, 32'h12345678, 0);
    vecs[1]  = mk(1,0,1,1,0,1, 3'd0,2'd2, 32'h0, 32'h80FF7F01, 32'h0, 5'd9,
                  1, 5'd9, SUB ? 32'hFFFFFFFF : 32'h80FF7F01, 0);
    vecs[2]  = mk(1,0,1,1,0,1, 3'd1,2'd3, 32'h0, 32'h80FF7F01, 32'h0, 5'd10,
                  1, 5'd10, SUB ? 32'h00000080 : 32'h80FF7F01, 0);
    vecs[3]  = mk(1,0,1,1,0,1, 3'd2,2'd2, 32'h0, 32'h80FF7F01, 32'h0, 5'd11,
                  1, 5'd11, SUB ? 32'hFFFF80FF : 32'h80FF7F01, 0);
    vecs[4]  = mk(1,0,1,1,0,1, 3'd3,2'd0, 32'h0, 32'h80FF7F01, 32'h0, 5'd12,
                  1, 5'd12, SUB ? 32'h00007F01 : 32'h80FF7F01, 0);
    vecs[5]  = mk(1,0,1,1,0,1, 3'd4,2'd2, 32'h0, 32'hDEADBEEF, 32'h0, 5'd13,
                  !SUB, SUB ? 5'd12 : 5'd13, SUB ? 32'h00007F01 : 32'hDEADBEEF, SUB);
    vecs[6]  = mk(1,0,1,0,0,1, 3'd4,2'd0, 32'h00000055, 32'h0, 32'h0, 5'd0,
                  0, 5'd0, 32'h00000055, 0);
    vecs[7]  = mk(1,0,1,1,1,1, 3'd4,2'd0, 32'h11111111, 32'h22222222, 32'h00400008, 5'd31,
                  1, 5'd31, 32'h00400008, 0);
    vecs[8]  = mk(0,0,1,0,0,1, 3'd4,2'd0, 32'h00000099, 32'h0, 32'h0, 5'd7,
                  0, 5'd31, 32'h00400008, 0);
    vecs[9]  = mk(1,1,1,0,0,1, 3'd4,2'd0, 32'h00000099, 32'h0, 32'h0, 5'd7,
                  0, 5'd31, 32'h00400008, 0);
    vecs[10] = mk(1,0,1,1,0,1, 3'd5,2'd0, 32'h0, 32'h80000001, 32'h0, 5'd3,
                  1, 5'd3, 32'h80000001, 0);
    vecs[11] = mk(1,0,1,0,0,0, 3'd4,2'd0, 32'h00000077, 32'h0, 32'h0, 5'd4,
                  0, 5'd4, 32'h00000077, 0);

    set_idle();
    reset = 1'b0;
    #3;
    check_output("reset_outputs", 64'({wb_we, wb_addr, wb_data, misalign, bus_err}), 64'(0));
    check_output("reset_ready", 64'(mem_ready), 64'(1));
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d_ready", i), 64'(mem_ready), 64'(1));
      tick();
      check_output($sformatf("vec%0d_out", i),
                   64'({wb_we, wb_addr, wb_data, misalign, bus_err}),
                   64'({vecs[i].exp_we, vecs[i].exp_addr, vecs[i].exp_data, vecs[i].exp_mis, 1'b0}));
    end

    // slow I/O read: data arrives on the third WAIT edge
    set_idle();
    mem_valid = 1'b1; MemIOtoReg = 1'b1; load_type = 3'd4; RegWrite = 1'b1; wreg = 5'd5;
    tick();
    check_output("slow_enter_we", 64'(wb_we), 64'(0));
    set_idle();
    low = 0;
    for (int k = 0; k < 3; k++) begin
      if (!mem_ready) low++;
      rdata_valid = (k == 2);
      read_data   = (k == 2) ? 32'hCAFEF00D : 32'h0;
      tick();
      if (k < 2) check_output("slow_no_early_we", 64'(wb_we), 64'(0));
    end
    check_output("slow_ready_low_cycles", 64'(low), 64'(3));
    check_output("slow_write", 64'({wb_we, wb_addr, wb_data}), 64'({1'b1, 5'd5, 32'hCAFEF00D}));
    check_output("slow_ready_back", 64'(mem_ready), 64'(1));
    set_idle();
    tick();
    check_output("slow_single_write", 64'(wb_we), 64'(0));

    // timeout: read never arrives
    mem_valid = 1'b1; MemIOtoReg = 1'b1; load_type = 3'd4; RegWrite = 1'b1; wreg = 5'd6;
    tick();
    set_idle();
    waits = 0; seen = 1'b0; wrote = 1'b0;
    while (!seen && waits < 40) begin
      tick();
      waits++;
      if (bus_err) seen = 1'b1;
      if (wb_we) wrote = 1'b1;
    end
    check_output("timeout_seen", 64'(seen), 64'(1));
    check_output("timeout_cycles", 64'(waits), 64'(WAIT_MAX + 1));
    check_output("timeout_no_write", 64'(wrote), 64'(0));
    check_output("timeout_ready", 64'(mem_ready), 64'(1));
    tick();
    check_output("timeout_pulse", 64'(bus_err), 64'(0));

    // flush while waiting beats arriving data
    mem_valid = 1'b1; MemIOtoReg = 1'b1; load_type = 3'd4; RegWrite = 1'b1; wreg = 5'd7;
    tick();
    set_idle();
    tick();
    flush = 1'b1; rdata_valid = 1'b1; read_data = 32'h00001234;
    tick();
    set_idle();
    check_output("flush_wait_out", 64'({wb_we, wb_addr, wb_data, misalign, bus_err}),
                 64'({1'b0, 5'd5, 32'hCAFEF00D, 1'b0, 1'b0}));
    check_output("flush_wait_ready", 64'(mem_ready), 64'(1));

    // reset mid-WAIT drops the pending load
    mem_valid = 1'b1; MemIOtoReg = 1'b1; load_type = 3'd4; RegWrite = 1'b1; wreg = 5'd9;
    tick();
    set_idle();
    check_output("rst_wait_entered", 64'(mem_ready), 64'(0));
    #2;
    reset = 1'b0;
    #1;
    check_output("rst_wait_ready", 64'(mem_ready), 64'(1));
    check_output("rst_wait_outputs", 64'({wb_we, wb_addr, wb_data}), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    rdata_valid = 1'b1; read_data = 32'hABCD0123;
    tick();
    check_output("rst_wait_lost", 64'({wb_we, wb_addr, wb_data}), 64'(0));

    // randomized traffic against the model, starting from reset
    set_idle();
    reset = 1'b0;
    #2;
    @(negedge clock);
    reset = 1'b1;
    m_pend = 1'b0; m_cnt = 0; m_lt = 3'd0; m_alo = 2'd0; m_rw = 1'b0; m_wreg = 5'd0;
    m_addr = 5'd0; m_data = 32'h0;
    for (int c = 0; c < 600; c++) begin
      mem_valid   = ($urandom_range(0, 9) < 8);
      flush       = ($urandom_range(0, 11) == 0);
      ALU_result  = $urandom;
      read_data   = $urandom;
      link_addr   = $urandom;
      MemIOtoReg  = 1'($urandom_range(0, 1));
      link        = ($urandom_range(0, 7) == 0);
      load_type   = 3'($urandom_range(0, 7));
      addr_lo     = 2'($urandom_range(0, 3));
      RegWrite    = ($urandom_range(0, 5) != 0);
      wreg        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rdata_valid = m_pend ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
      check_output("rand_ready", 64'(mem_ready), 64'(!m_pend));
      model_step();
      tick();
      check_output("rand_out", 64'({wb_we, wb_addr, wb_data, misalign, bus_err}),
                   64'({e_we, m_addr, m_data, e_mis, e_berr}));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
